decoder_scan_ctrl: RTL and testbench

- Sequencer directly upstream of the 4-to-16 enable decoder; generates its 4-bit select and enable.
- Two operations: a single select held for a programmable dwell, or a 16-entry sweep with a one-cycle break between entries.
- Guarantees at most one decoder output is ever active and enable is never asserted while select changes.
- Used for register-file write strobing and for LED/row scanning.

---
 rtl/decoder_scan_ctrl.sv | 105 ++++++++++
 tb/tb_decoder_scan_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// Select/enable sequencer for a 4-to-16 enable decoder: single-select dwell or 16-entry sweep.
// Enable drops for a break cycle around every select change, so only one decoder output is ever active.
module decoder_scan_ctrl #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [3:0]         addrIn,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         selOut,
  output logic               enOut,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP,
    DONE
  } state_e;

  state_e             state_q;
  logic               mode_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dcnt_q;
  logic [3:0]         ecnt_q;
  logic [3:0]         sel_q;
  logic               en_q;
  logic               busy_q;
  logic               done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      dwell_q <= '0;
      dcnt_q  <= '0;
      ecnt_q  <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort && state_q != IDLE) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          en_q   <= 1'b0;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            mode_q  <= mode;
            dwell_q <= dwell;
            sel_q   <= addrIn;
            dcnt_q  <= '0;
            ecnt_q  <= '0;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          // Counter stops at the match, so it never wraps even at maximum dwell.
          if (dcnt_q == dwell_q) begin
            en_q <= 1'b0;
            if (!mode_q || ecnt_q == 4'd15) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= GAP;
            end
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        GAP: begin
          sel_q   <= sel_q + 4'd1;
          ecnt_q  <= ecnt_q + 4'd1;
          dcnt_q  <= '0;
          en_q    <= 1'b1;
          state_q <= ACTIVE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign selOut = sel_q;
  assign enOut  = en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: per-operation expected timelines queued at start, popped every cycle.
module tb_decoder_scan_ctrl;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset, start, abort, mode;
  logic [3:0]    addrIn;
  logic [DW-1:0] dwell;
  logic [3:0]    selOut;
  logic          enOut, busy, done;

  decoder_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .mode   (mode),
    .addrIn (addrIn),
    .dwell  (dwell),
    .selOut (selOut),
    .enOut  (enOut),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic       en;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic       mode;
    logic [3:0] addr;
    logic [7:0] dwell;
    int         poke_at;
    int         abort_at;
    int         rst_at;
    logic       abort_with_start;
  } vec_t;

  obs_t       exp_q[$];
  vec_t       tbl[9];
  int         n_vec = 0;
  int         n_err = 0;
  logic       prev_en = 1'b0;
  logic [3:0] prev_sel = 4'd0;

  task automatic check(input string name, input obs_t e);
    logic [15:0] dec;
    dec = enOut ? (16'd1 << selOut) : 16'd0;
    n_vec++;
    if (selOut !== e.sel || enOut !== e.en || busy !== e.busy || done !== e.done) begin
      n_err++;
      $display("FAIL %s: got sel=%0d en=%0b busy=%0b done=%0b, want sel=%0d en=%0b busy=%0b done=%0b",
               name, selOut, enOut, busy, done, e.sel, e.en, e.busy, e.done);
    end
    n_vec++;
    if ($countones(dec) > 1 || (prev_en && enOut && selOut !== prev_sel)) begin
      n_err++;
      $display("FAIL %s_onehot: got dec=%h sel=%0d (prev en=%0b sel=%0d), want one output, stable select",
               name, dec, selOut, prev_en, prev_sel);
    end
    prev_en  = enOut;
    prev_sel = selOut;
  endtask

  // Timeline from the operation description: each entry dwell+1 enabled cycles, break between entries.
  task automatic build(input vec_t v);
    int         n;
    int         k;
    logic [3:0] s;
    n = v.mode ? 16 : 1;
    s = v.addr;
    exp_q.delete();
    for (int e = 0; e < n; e++) begin
      s = v.addr + 4'(e);
      for (int c = 0; c <= int'(v.dwell); c++) exp_q.push_back('{s, 1'b1, 1'b1, 1'b0});
      if (e != n - 1) exp_q.push_back('{s, 1'b0, 1'b1, 1'b0});
    end
    exp_q.push_back('{s, 1'b0, 1'b1, 1'b1});
    exp_q.push_back('{s, 1'b0, 1'b0, 1'b0});
    exp_q.push_back('{s, 1'b0, 1'b0, 1'b0});
    if (v.abort_at >= 0) begin
      k = v.abort_at;
      s = exp_q[k].sel;
      while (exp_q.size() > k + 1) void'(exp_q.pop_back());
      exp_q.push_back('{s, 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{s, 1'b0, 1'b0, 1'b0});
    end
    if (v.rst_at >= 0) begin
      k = v.rst_at;
      while (exp_q.size() > k + 1) void'(exp_q.pop_back());
      exp_q.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    obs_t e;
    @(negedge clk);
    build(v);
    start  = 1'b1;
    mode   = v.mode;
    addrIn = v.addr;
    dwell  = v.dwell;
    abort  = v.abort_with_start;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      start  = 1'b0;
      abort  = 1'b0;
      reset  = 1'b0;
      mode   = 1'($urandom);
      addrIn = 4'($urandom);
      dwell  = 8'($urandom);
      e = exp_q.pop_front();
      check($sformatf("v%0d_c%0d", id, i), e);
      if (i == v.poke_at) begin
        start  = 1'b1;
        addrIn = 4'd3;
      end
      if (i == v.abort_at) abort = 1'b1;
      if (i == v.rst_at)   reset = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    mode   = 1'b0;
    addrIn = 4'd0;
    dwell  = '0;

    //          mode  addr   dwell    poke abort rst abort_with_start
    tbl[0] = '{1'b0, 4'd9,  8'd2,   -1,  -1,  -1, 1'b0};
    tbl[1] = '{1'b1, 4'd14, 8'd0,   -1,  -1,  -1, 1'b0};
    tbl[2] = '{1'b1, 4'd14, 8'd0,    7,  -1,  -1, 1'b0};
    tbl[3] = '{1'b1, 4'd0,  8'd4,   -1,  13,  -1, 1'b0};
    tbl[4] = '{1'b0, 4'd4,  8'd0,   -1,  -1,  -1, 1'b1};
    tbl[5] = '{1'b1, 4'd5,  8'd1,   -1,  -1,   2, 1'b0};
    tbl[6] = '{1'b0, 4'd7,  8'd255, -1,  -1,  -1, 1'b0};
    tbl[7] = '{1'b1, 4'd3,  8'd2,    0,  -1,  -1, 1'b0};
    tbl[8] = '{1'b0, 4'd15, 8'd3,   -1,   4,  -1, 1'b0};

    repeat (2) @(negedge clk);
    check("reset", '{4'd0, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort", '{4'd0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    @(negedge clk);
    check("final_idle", '{4'd15, 1'b0, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
